// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family.
package counter_pkg;

    // Overflow/underflow behaviour selected by the mode input.
    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } mode_e;

    // Legal counter width range.
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and event logic for the bounded up/down counter.
// inc/dec are expected to be already gated by enable; both high means hold.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  mode_e            mode,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] next,
    output logic             ovf,
    output logic             unf,
    output logic             wrap
);

    // Decide the next count and flag any boundary crossing.
    always_comb begin
        next = count;
        ovf  = 1'b0;
        unf  = 1'b0;
        wrap = 1'b0;
        if (inc && !dec) begin
            if (count < limit) begin
                next = count + WIDTH'(1);
            end else begin
                // count may sit above a freshly lowered limit; both cases are an overflow
                ovf = 1'b1;
                if (mode == MODE_WRAP) begin
                    next = '0;
                    wrap = 1'b1;
                end else begin
                    next = limit;
                end
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                next = count - WIDTH'(1);
            end else begin
                unf = 1'b1;
                if (mode == MODE_WRAP) begin
                    next = limit;
                    wrap = 1'b1;
                end else begin
                    next = '0;
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Bounded up/down counter with runtime limit, wrap/saturate modes and sticky flags.
// All next-state arithmetic lives in counter_next_calc; this level holds the registers.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    input  logic             decrement,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_limit,
    output logic             wrap_pulse,
    output logic             ovf_flag,
    output logic             unf_flag
);

    localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] calc_next;
    logic             calc_ovf, calc_unf, calc_wrap;
    logic [WIDTH-1:0] load_clamped;

    counter_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .count (count_q),
        .limit (limit),
        .mode  (mode_e'(mode)),
        .inc   (enable & increment),
        .dec   (enable & decrement),
        .next  (calc_next),
        .ovf   (calc_ovf),
        .unf   (calc_unf),
        .wrap  (calc_wrap)
    );

    // A load never leaves the count above the current limit.
    assign load_clamped = (load_value > limit) ? limit : load_value;

    // Select next state: load beats counting; set beats clear on sticky flags.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = clear_flags ? 1'b0 : ovf_q;
        unf_d   = clear_flags ? 1'b0 : unf_q;
        if (load) begin
            count_d = load_clamped;
        end else begin
            count_d = calc_next;
            wrap_d  = calc_wrap;
            if (calc_ovf) begin
                ovf_d = 1'b1;
            end
            if (calc_unf) begin
                unf_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ResetCount;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign ovf_flag   = ovf_q;
    assign unf_flag   = unf_q;
    assign at_zero    = (count_q == '0);
    assign at_limit   = (count_q >= limit);

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the counter width in bits, with a legal range of 2..32.
REQ-002 Parameter RESET_VALUE SHALL default to 0 and set the count loaded on reset; it SHALL be no greater than 2**WIDTH-1.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 enable  input  1  SHALL gate counting; when low, increment/decrement are ignored.
REQ-006 increment  input  1  SHALL request count+1 this cycle.
REQ-007 decrement  input  1  SHALL request count-1 this cycle.
REQ-008 load  input  1  SHALL load load_value, independent of enable.
REQ-009 load_value  input  WIDTH  SHALL be the value to load.
REQ-010 limit  input  WIDTH  SHALL be the runtime upper bound; the count range is 0..limit.
REQ-011 mode  input  1  SHALL select 0 = WRAP or 1 = SATURATE.
REQ-012 clear_flags  input  1  SHALL clear the sticky flags.
REQ-013 count  output  WIDTH  SHALL be the registered count.
REQ-014 at_zero / at_limit  output  1 each  SHALL be combinational: count==0 / count>=limit.
REQ-015 wrap_pulse  output  1  SHALL be a registered one-cycle pulse on any wrap event.
REQ-016 ovf_flag / unf_flag  output  1 each  SHALL be registered sticky overflow / underflow flags.

Function
REQ-017 Per-cycle priority SHALL be: reset > load > counting > hold.
REQ-018 A load with load_value>limit SHALL set count to limit, so that count never exceeds limit after a load.
REQ-019 Counting SHALL occur only when enable=1 and exactly one of increment/decrement is 1; both high or both low SHALL hold the count.
REQ-020 An increment with count<limit SHALL produce count+1.
REQ-021 An increment with count>=limit SHALL produce 0 in WRAP mode and limit in SATURATE mode; both modes SHALL set ovf_flag.
REQ-022 A decrement with count>0 SHALL produce count-1, including when count>limit after limit was lowered.
REQ-023 A decrement with count==0 SHALL produce limit in WRAP mode and hold 0 in SATURATE mode; both modes SHALL set unf_flag.
REQ-024 wrap_pulse SHALL be 1 in the cycle following a WRAP-mode wrap, coincident with the new count; it SHALL never assert in SATURATE mode or on load.
REQ-025 If set and clear_flags occur in the same cycle, set SHALL win; otherwise clear_flags=1 SHALL zero both sticky flags next cycle.
REQ-026 Changing limit or mode SHALL take effect on the next counting decision; count SHALL not be modified by the change alone.
REQ-027 With limit==0, the count SHALL remain 0; increment or decrement SHALL set the corresponding sticky flag, and in WRAP mode SHALL also pulse wrap_pulse.
REQ-028 All arithmetic SHALL be WIDTH-bit unsigned, with no carry beyond WIDTH.

Reset
REQ-029 Reset SHALL force count=RESET_VALUE, wrap_pulse=0, ovf_flag=0 and unf_flag=0 in the next cycle, overriding load, counting and clear_flags.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight request; counting SHALL resume on the first cycle after reset deasserts.

Structure
REQ-031 Mode encodings (MODE_WRAP=0, MODE_SATURATE=1) SHALL reside in shared package counter_pkg.
REQ-032 Next-count/event logic SHALL be sub-module counter_next_calc (combinational: count, limit, mode, inc, dec -> next, ovf, unf, wrap); the top SHALL hold the registers only.

Verification (WIDTH=4, limit=9 unless noted)
REQ-033 Reset pulse with load=1, load_value=5 -> count=0, at_zero=1, all flags 0.
REQ-034 WRAP mode, load 8, increment for 2 cycles -> count 9 then 0; wrap_pulse=1 exactly on the 0 cycle; ovf_flag=1.
REQ-035 SATURATE mode, count=9, increment for 3 cycles -> count stays 9, wrap_pulse=0, ovf_flag=1; then clear_flags -> ovf_flag=0.
REQ-036 WRAP mode, count=0, decrement -> count=9, unf_flag=1; SATURATE mode, count=0, decrement -> count=0, unf_flag=1.
REQ-037 increment=decrement=1 for 2 cycles -> count unchanged; load_value=12 -> count=9; enable=0 with increment=1 -> count unchanged.
REQ-038 count=7, limit lowered to 3, increment -> 0 (WRAP) or 3 (SATURATE); decrement from 7 -> 6.
